muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter Dbits, default 32, meaning operand and HI/LO register width.
REQ-002 The block SHALL have port clock  input  1  the single clock; all state changes on posedge clock.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request strobe, sampled on posedge clock.
REQ-005 The block SHALL have port op  input  2  operation: 2'b00 MULTU, 2'b01 DIVU, 2'b10 MTHI, 2'b11 MTLO.
REQ-006 The block SHALL have port a  input  Dbits  rs operand from the register file's first read port (dividend, multiplicand, MT source).
REQ-007 The block SHALL have port b  input  Dbits  rt operand from the register file's second read port (divisor, multiplier).
REQ-008 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse for MULTU/DIVU.
REQ-010 The block SHALL have ports hi and lo  output  Dbits each  architectural HI/LO registers, to be consumed by MFHI/MFLO writeback into the register file.

Function
REQ-011 The FSM SHALL have states IDLE, MUL and DIV.
REQ-012 In IDLE, start=1 with op MULTU or DIVU SHALL capture a and b, clear the iteration counter, and move to MUL or DIV respectively.
REQ-013 In IDLE, start=1 with op MTHI SHALL load hi<=a at that edge, and op MTLO SHALL load lo<=a at that edge; neither SHALL assert busy or done.
REQ-014 busy SHALL be 1 exactly while the state is MUL or DIV, for exactly Dbits cycles per operation.
REQ-015 MUL SHALL be unsigned shift-add, one multiplier bit per cycle, using a 2*Dbits-bit product accumulator.
REQ-016 DIV SHALL be unsigned restoring division, one quotient bit per cycle, with a Dbits+1-bit partial remainder.
REQ-017 On the Dbits-th iteration edge, the FSM SHALL write the result into hi/lo and return to IDLE; done SHALL be 1 in the following cycle only.
REQ-018 MULTU SHALL produce hi = upper Dbits bits and lo = lower Dbits bits of the full product.
REQ-019 DIVU SHALL produce lo = quotient and hi = remainder.
REQ-020 DIVU with b=0 SHALL complete in the normal Dbits cycles with lo = all ones and hi = a, with no exception or flag.
REQ-021 hi and lo SHALL hold their prior values throughout MUL/DIV, because working registers are separate from hi/lo; the update SHALL be atomic at completion.
REQ-022 start while busy=1 SHALL be ignored entirely, with no effect on operands, state or hi/lo.
REQ-023 start in the cycle where done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-024 Inputs a and b SHALL NOT be required to stay stable after the capture edge.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and working registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no partial result SHALL reach hi/lo, and no done pulse SHALL follow deassertion.
REQ-027 After reset deassertion, the first start SHALL be accepted at the first posedge clock.

Structure
REQ-028 Package mips_pkg SHALL hold the muldiv_op_t enum (MULTU, DIVU, MTHI, MTLO) and the muldiv_state_t enum (IDLE, MUL, DIV).
REQ-029 The iteration counter SHALL be $clog2(Dbits)+1 bits wide and local to the module.
REQ-030 No sub-module SHALL be used; the datapath and FSM SHALL live in the single module muldiv_unit.

Verification
REQ-031 The bench SHALL cover: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy for 32 cycles, then done pulse with hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-032 The bench SHALL cover: DIVU a=100, b=7 -> after 32 busy cycles, lo=14, hi=2, done for exactly one cycle.
REQ-033 The bench SHALL cover: DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5 after 32 cycles.
REQ-034 The bench SHALL cover: MTHI a=32'h12345678, then MULTU 3x4 with a second start (DIVU 9/2) at busy cycle 10 -> the second start is ignored, hi stays 32'h12345678 until completion, then hi=0, lo=12.
REQ-035 The bench SHALL cover: MULTU 6x7, then reset_n low at busy cycle 15 -> hi=lo=0, busy=0 immediately, and no done after release.
REQ-036 The bench SHALL cover: start DIVU 9/2 in the done cycle of a prior MULTU -> accepted, and after 32 cycles lo=4, hi=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Operation codes and FSM states.
package mips_pkg;

   typedef enum logic [1:0] {
      MULTU = 2'b00,
      DIVU  = 2'b01,
      MTHI  = 2'b10,
      MTLO  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU with architectural HI/LO.
// One bit per cycle; HI/LO updated atomically at completion.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int Dbits = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [Dbits-1:0] a,
   input  logic [Dbits-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [Dbits-1:0] hi,
   output logic [Dbits-1:0] lo
);

   localparam int CW = $clog2(Dbits) + 1;
   localparam logic [CW-1:0] LAST = CW'(Dbits - 1);

   muldiv_state_t      r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*Dbits-1:0] r_acc;
   logic [Dbits-1:0]   r_opnd;
   logic [Dbits-1:0]   r_hi;
   logic [Dbits-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;

   logic [Dbits:0]     w_sum;
   logic [2*Dbits-1:0] w_mul_nx;
   logic [Dbits:0]     w_part;
   logic [Dbits:0]     w_diff;
   logic               w_ge;
   logic [2*Dbits-1:0] w_div_nx;
   logic [2*Dbits-1:0] w_acc_nx;

   // Shift-add step: acc = {product_hi, multiplier/product_lo}
   assign w_sum    = {1'b0, r_acc[2*Dbits-1:Dbits]} + {1'b0, r_opnd};
   assign w_mul_nx = r_acc[0] ? {w_sum, r_acc[Dbits-1:1]}
                              : {1'b0, r_acc[2*Dbits-1:1]};

   // Restoring step: acc = {remainder, dividend/quotient}.
   // The remainder stays below the divisor, so the difference
   // MSB is a clean borrow flag.
   assign w_part   = r_acc[2*Dbits-1:Dbits-1];
   assign w_diff   = w_part - {1'b0, r_opnd};
   assign w_ge     = ~w_diff[Dbits];
   assign w_div_nx = {w_ge ? w_diff[Dbits-1:0] : w_part[Dbits-1:0],
                      r_acc[Dbits-2:0], w_ge};

   assign w_acc_nx = (r_state == MUL) ? w_mul_nx : w_div_nx;

   // FSM, working datapath and HI/LO with registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  unique case (muldiv_op_t'(op))
                     MULTU: begin
                        r_acc   <= {{Dbits{1'b0}}, b};
                        r_opnd  <= a;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                     end
                     DIVU: begin
                        r_acc   <= {{Dbits{1'b0}}, a};
                        r_opnd  <= b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= DIV;
                     end
                     MTHI: r_hi <= a;
                     MTLO: r_lo <= a;
                  endcase
               end
            end
            MUL, DIV: begin
               r_acc <= w_acc_nx;
               if (r_cnt == LAST) begin
                  r_hi    <= w_acc_nx[2*Dbits-1:Dbits];
                  r_lo    <= w_acc_nx[Dbits-1:0];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
